disp_sched: RTL

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/disp_sched.sv
// disp_sched -- four-digit display scheduler.
//
// Generates the digit-multiplexer scan strobe, a free-running blink phase, and
// chooses what the four digits show: the live background value (with optional
// per-digit blinking) or a latched message held for HOLD_TICKS strobes.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   base_val[15:0]    background digits, [15:12] is the leftmost digit
//   blink_en[3:0]     per-digit blink enable, bit3 is the leftmost digit
//   msg_req           level request to latch and show msg_val
//   msg_val[15:0]     message digits, same packing as base_val
//   msg_cancel        drop the active message (wins over everything)
//   mux_clk           one-cycle scan strobe, period MUX_DIV
//   val1..val4        registered digit codes, 4'hF is blank
//   msg_ack           one-cycle pulse per latch (stays high while msg_req held)
//   msg_busy          registered "showing a message" flag
module disp_sched #(
    parameter int MUX_DIV     = 100000,
    parameter int HOLD_TICKS  = 500,
    parameter int BLINK_TICKS = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] base_val,
    input  logic [3:0]  blink_en,
    input  logic        msg_req,
    input  logic [15:0] msg_val,
    input  logic        msg_cancel,
    output logic        mux_clk,
    output logic [3:0]  val1,
    output logic [3:0]  val2,
    output logic [3:0]  val3,
    output logic [3:0]  val4,
    output logic        msg_ack,
    output logic        msg_busy
);

    localparam int PW = $clog2(MUX_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(MUX_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic {SHOW_BASE, SHOW_MSG} state_t;

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [15:0]   msg_latch, latch_n;
    logic          ack_n;
    logic [15:0]   disp_n;

    // Prescaler. The strobe is registered off the terminal count, so it is
    // high the cycle after the counter sits at MUX_DIV-1; the first strobe
    // after reset therefore lands exactly MUX_DIV edges after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            mux_clk <= 1'b0;
        end else begin
            mux_clk <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    // Blink phase runs regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (mux_clk) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHOW_BASE;
            hold_cnt  <= '0;
            msg_latch <= 16'hFFFF;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            msg_latch <= latch_n;
        end
    end

    // Priority: cancel (only meaningful while showing), then request
    // (retriggers reload the hold), then hold countdown on strobes.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        latch_n = msg_latch;
        ack_n   = 1'b0;
        if (state == SHOW_MSG && msg_cancel) begin
            state_n = SHOW_BASE;
            hold_n  = '0;
        end else if (msg_req && !msg_cancel) begin
            state_n = SHOW_MSG;
            hold_n  = HOLD_LOAD;
            latch_n = msg_val;
            ack_n   = 1'b1;
        end else if (state == SHOW_MSG && mux_clk) begin
            if (hold_cnt == HW'(1)) begin
                state_n = SHOW_BASE;
                hold_n  = '0;
            end else begin
                hold_n = hold_cnt - HW'(1);
            end
        end
    end

    // Digit source selection; messages are never blanked.
    always_comb begin
        disp_n = base_val;
        if (state == SHOW_MSG) begin
            disp_n = msg_latch;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (blink_en[i] && blink_phase) disp_n[i*4 +: 4] = 4'hF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val1     <= 4'hF;
            val2     <= 4'hF;
            val3     <= 4'hF;
            val4     <= 4'hF;
            msg_ack  <= 1'b0;
            msg_busy <= 1'b0;
        end else begin
            val1     <= disp_n[15:12];
            val2     <= disp_n[11:8];
            val3     <= disp_n[7:4];
            val4     <= disp_n[3:0];
            msg_ack  <= ack_n;
            msg_busy <= (state == SHOW_MSG);
        end
    end

endmodule
